// File: rtl/xor_stream_checker_if.sv
// Stream-in / result-out bundle for xor_stream_checker.
// The slave modport is the checker's view; master is the source/consumer side.
interface xor_stream_checker_if #(
    parameter int WIDTH   = 8,
    parameter int MAX_LEN = 16
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic             mode;
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_data;
    logic             s_last;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_sum;
    logic             m_parity;
    logic             m_err;
    logic [LEN_W-1:0] m_len;
    logic             m_ovf;

    modport slave (
        input  mode, s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_sum, m_parity, m_err, m_len, m_ovf
    );

    modport master (
        output mode, s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_sum, m_parity, m_err, m_len, m_ovf
    );
endinterface

// File: rtl/xor_stream_checker.sv
// Folds a framed stream into a running XOR checksum and reports sum, parity,
// length and overflow through a single-entry valid/ready result register.
module xor_stream_checker #(
    parameter int WIDTH   = 8,
    parameter int MAX_LEN = 16
) (
    input logic                 clk,
    input logic                 rst,
    xor_stream_checker_if.slave bus
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    localparam logic [0:0] ACCUM = 1'b0;
    localparam logic [0:0] HOLD  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             ovf_q, ovf_d;
    logic             first_q, first_d;
    logic             mode_q, mode_d;

    logic             m_valid_q, m_valid_d;
    logic [WIDTH-1:0] m_sum_q, m_sum_d;
    logic             m_parity_q, m_parity_d;
    logic             m_err_q, m_err_d;
    logic [LEN_W-1:0] m_len_q, m_len_d;
    logic             m_ovf_q, m_ovf_d;

    logic             accept;
    logic [WIDTH-1:0] acc_nx;
    logic [LEN_W-1:0] len_nx;
    logic             ovf_nx;
    logic             mode_nx;

    assign bus.s_ready = (state_q == ACCUM);
    assign accept      = bus.s_valid && bus.s_ready;

    // Post-beat values, shared by the accumulator update and the result capture
    // so a last beat folds into m_sum on the same edge it is accepted.
    always_comb begin
        acc_nx  = acc_q;
        len_nx  = len_q;
        ovf_nx  = ovf_q;
        mode_nx = mode_q;
        if (first_q) begin
            acc_nx  = bus.s_data;
            len_nx  = LEN_ONE;
            ovf_nx  = 1'b0;
            mode_nx = bus.mode;
        end else begin
            acc_nx = acc_q ^ bus.s_data;
            if (len_q < LEN_MAX) begin
                len_nx = len_q + LEN_ONE;
            end else begin
                ovf_nx = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        len_d      = len_q;
        ovf_d      = ovf_q;
        first_d    = first_q;
        mode_d     = mode_q;
        m_valid_d  = m_valid_q;
        m_sum_d    = m_sum_q;
        m_parity_d = m_parity_q;
        m_err_d    = m_err_q;
        m_len_d    = m_len_q;
        m_ovf_d    = m_ovf_q;

        case (state_q)
            ACCUM: begin
                if (accept) begin
                    acc_d   = acc_nx;
                    len_d   = len_nx;
                    ovf_d   = ovf_nx;
                    mode_d  = mode_nx;
                    first_d = 1'b0;
                    if (bus.s_last) begin
                        m_sum_d    = acc_nx;
                        m_parity_d = ^acc_nx;
                        m_err_d    = mode_nx && (acc_nx != '0);
                        m_len_d    = len_nx;
                        m_ovf_d    = ovf_nx;
                        m_valid_d  = 1'b1;
                        state_d    = HOLD;
                    end
                end
            end
            HOLD: begin
                if (bus.m_ready) begin
                    m_valid_d = 1'b0;
                    acc_d     = '0;
                    len_d     = '0;
                    ovf_d     = 1'b0;
                    first_d   = 1'b1;
                    state_d   = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ACCUM;
            acc_q      <= '0;
            len_q      <= '0;
            ovf_q      <= 1'b0;
            first_q    <= 1'b1;
            mode_q     <= 1'b0;
            m_valid_q  <= 1'b0;
            m_sum_q    <= '0;
            m_parity_q <= 1'b0;
            m_err_q    <= 1'b0;
            m_len_q    <= '0;
            m_ovf_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            len_q      <= len_d;
            ovf_q      <= ovf_d;
            first_q    <= first_d;
            mode_q     <= mode_d;
            m_valid_q  <= m_valid_d;
            m_sum_q    <= m_sum_d;
            m_parity_q <= m_parity_d;
            m_err_q    <= m_err_d;
            m_len_q    <= m_len_d;
            m_ovf_q    <= m_ovf_d;
        end
    end

    assign bus.m_valid  = m_valid_q;
    assign bus.m_sum    = m_sum_q;
    assign bus.m_parity = m_parity_q;
    assign bus.m_err    = m_err_q;
    assign bus.m_len    = m_len_q;
    assign bus.m_ovf    = m_ovf_q;
endmodule

// File: tb/tb_xor_stream_checker.sv
// Directed bench for xor_stream_checker (WIDTH=8, MAX_LEN=16) with
// hand-computed expected results.
module tb_xor_stream_checker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nvec = 0;
    int   nerr = 0;

    xor_stream_checker_if #(.WIDTH(8), .MAX_LEN(16)) bus ();

    xor_stream_checker #(.WIDTH(8), .MAX_LEN(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic last, input logic md);
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = last;
        bus.mode    = md;
        tick();
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        bus.s_data  = 8'hC3;
    endtask

    task automatic check_res(input string tag, input logic [7:0] sum, input logic par,
                             input logic [4:0] len, input logic err, input logic ovf);
        chk({tag, ".m_valid"},  32'(bus.m_valid),  32'd1);
        chk({tag, ".m_sum"},    32'(bus.m_sum),    32'(sum));
        chk({tag, ".m_parity"}, 32'(bus.m_parity), 32'(par));
        chk({tag, ".m_len"},    32'(bus.m_len),    32'(len));
        chk({tag, ".m_err"},    32'(bus.m_err),    32'(err));
        chk({tag, ".m_ovf"},    32'(bus.m_ovf),    32'(ovf));
        chk({tag, ".s_ready"},  32'(bus.s_ready),  32'd0);
    endtask

    task automatic take(input string tag);
        bus.m_ready = 1'b1;
        tick();
        bus.m_ready = 1'b0;
        chk({tag, ".post_m_valid"}, 32'(bus.m_valid), 32'd0);
        chk({tag, ".post_s_ready"}, 32'(bus.s_ready), 32'd1);
    endtask

    initial begin
        bus.mode    = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b0;

        // Reset state
        tick(); tick();
        rst = 1'b0;
        chk("rst.s_ready",  32'(bus.s_ready),  32'd1);
        chk("rst.m_valid",  32'(bus.m_valid),  32'd0);
        chk("rst.m_sum",    32'(bus.m_sum),    32'd0);
        chk("rst.m_parity", 32'(bus.m_parity), 32'd0);
        chk("rst.m_err",    32'(bus.m_err),    32'd0);
        chk("rst.m_len",    32'(bus.m_len),    32'd0);
        chk("rst.m_ovf",    32'(bus.m_ovf),    32'd0);

        // 1: generate mode, three beats
        send(8'h12, 1'b0, 1'b0);
        chk("gen3.no_early_valid", 32'(bus.m_valid), 32'd0);
        send(8'h34, 1'b0, 1'b0);
        send(8'h56, 1'b1, 1'b0);
        check_res("gen3", 8'h70, 1'b1, 5'd3, 1'b0, 1'b0);

        // 3: backpressure with new data offered while holding
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hEE;
        bus.s_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_res("bp.hold", 8'h70, 1'b1, 5'd3, 1'b0, 1'b0);
        end
        take("bp");
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        send(8'h0F, 1'b0, 1'b0);
        send(8'hF0, 1'b1, 1'b0);
        check_res("bp.fresh", 8'hFF, 1'b0, 5'd2, 1'b0, 1'b0);
        take("bp.fresh");

        // 2: check mode, good frame then corrupted frame (mode drops mid-frame)
        send(8'h12, 1'b0, 1'b1);
        send(8'h34, 1'b0, 1'b1);
        send(8'h56, 1'b0, 1'b1);
        send(8'h70, 1'b1, 1'b1);
        check_res("chk.good", 8'h00, 1'b0, 5'd4, 1'b0, 1'b0);
        take("chk.good");
        send(8'h12, 1'b0, 1'b1);
        send(8'h34, 1'b0, 1'b0);
        send(8'h56, 1'b0, 1'b0);
        send(8'h71, 1'b1, 1'b0);
        check_res("chk.bad", 8'h01, 1'b1, 5'd4, 1'b1, 1'b0);
        take("chk.bad");

        // 4: single-beat frames
        send(8'hA5, 1'b1, 1'b0);
        check_res("single.gen", 8'hA5, 1'b0, 5'd1, 1'b0, 1'b0);
        take("single.gen");
        send(8'h00, 1'b1, 1'b1);
        check_res("single.chk", 8'h00, 1'b0, 5'd1, 1'b0, 1'b0);
        take("single.chk");
        send(8'h5A, 1'b1, 1'b1);
        check_res("single.chkbad", 8'h5A, 1'b0, 5'd1, 1'b1, 1'b0);
        take("single.chkbad");

        // Exactly MAX_LEN beats: saturates without overflow
        for (int i = 0; i < 15; i++) send(8'h01, 1'b0, 1'b0);
        send(8'h02, 1'b1, 1'b0);
        check_res("len16", 8'h03, 1'b0, 5'd16, 1'b0, 1'b0);
        take("len16");

        // 5: overflow, back to back then with idle gaps
        for (int i = 0; i < 20; i++) send(8'h01, 1'b0, 1'b0);
        send(8'h03, 1'b1, 1'b0);
        check_res("ovf", 8'h03, 1'b0, 5'd16, 1'b0, 1'b1);
        take("ovf");
        for (int i = 0; i < 20; i++) begin
            send(8'h01, 1'b0, 1'b0);
            bus.s_data = 8'hFF;
            repeat ($urandom_range(0, 2)) tick();
        end
        send(8'h03, 1'b1, 1'b0);
        check_res("ovf.gaps", 8'h03, 1'b0, 5'd16, 1'b0, 1'b1);
        take("ovf.gaps");

        // 6: reset mid-frame, then reset while holding a result
        send(8'hFF, 1'b0, 1'b0);
        send(8'h0F, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid.m_valid", 32'(bus.m_valid), 32'd0);
        chk("rstmid.s_ready", 32'(bus.s_ready), 32'd1);
        send(8'h11, 1'b1, 1'b0);
        check_res("rstmid", 8'h11, 1'b0, 5'd1, 1'b0, 1'b0);
        take("rstmid");
        send(8'h22, 1'b1, 1'b1);
        check_res("rsthold.pre", 8'h22, 1'b0, 5'd1, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rsthold.m_valid", 32'(bus.m_valid), 32'd0);
        chk("rsthold.s_ready", 32'(bus.s_ready), 32'd1);
        chk("rsthold.m_sum",   32'(bus.m_sum),   32'd0);
        tick();
        chk("rsthold.stays",   32'(bus.m_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
